mux2_1_wide_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one WIDTH-bit datapath. It drives the select of an internal mux2_1_wide and places the winning beat in a registered output stage with a valid/ready handshake. It supports multi-beat bursts with ownership locking. Sits in front of shared write paths, e.g. a writeback bus contended by two producers.

---
 rtl/mux2_1_wide_arbiter_pkg.sv | 5 +
 rtl/mux2_1_wide.sv | 10 +
 rtl/mux2_1_wide_arbiter.sv | 74 +++++++
 tb/tb_mux2_1_wide_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mux2_1_wide_arbiter_pkg.sv
// mux2_1_wide_arbiter_pkg: ownership state type and requester count shared by the arbiter
package mux2_1_wide_arbiter_pkg;
   localparam int NUM_REQ = 2;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
endpackage

// File: rtl/mux2_1_wide.sv
// mux2_1_wide: WIDTH-bit two-input mux, sel picks in[sel]
module mux2_1_wide #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] in [0:1],
   input  logic             sel,
   output logic [WIDTH-1:0] out
);
   assign out = in[sel];
endmodule

// File: rtl/mux2_1_wide_arbiter.sv
// mux2_1_wide_arbiter: two-requester round-robin arbiter with registered output; ARB_BURST_LOCK_EN keeps ownership until last
module mux2_1_wide_arbiter
   import mux2_1_wide_arbiter_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [WIDTH-1:0]   in [0:NUM_REQ-1],
   input  logic [NUM_REQ-1:0] last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [WIDTH-1:0]   out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               owner
);
   arb_state_t       r_state;
   logic             r_rr;
   logic             r_owner;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] w_mux;
   logic             w_can_load;
   logic             w_xfer;
   logic             w_win;
   logic             w_last;

   mux2_1_wide #(.WIDTH(WIDTH)) u_mux (.in(in), .sel(r_owner), .out(w_mux));

   // a beat moves only for the owner and only when the output slot is free or draining
   always_comb begin
      w_can_load = !r_out_valid || out_ready;
      w_xfer     = (r_state == OWN0 || r_state == OWN1) && req[r_owner] && w_can_load;
      w_win      = &req ? r_rr : req[1];
   end

`ifdef ARB_BURST_LOCK_EN
   assign w_last = last[r_owner];
`else
   assign w_last = last[r_owner] | 1'b1;
`endif

   assign gnt       = {w_xfer & r_owner, w_xfer & ~r_owner};
   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign owner     = r_owner;

   // arbitration, burst ownership and the output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_rr        <= 1'b0;
         r_owner     <= 1'b0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (r_state == IDLE && |req) begin
            r_owner <= w_win;
            r_state <= w_win ? OWN1 : OWN0;
         end
         if (w_xfer) begin
            r_out       <= w_mux;
            r_out_valid <= 1'b1;
            if (w_last) begin
               r_state <= IDLE;
               r_rr    <= ~r_owner;
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux2_1_wide_arbiter.sv
// tb_mux2_1_wide_arbiter: directed checks of arbitration, backpressure and async reset; ARB_BURST_LOCK_EN adds a burst check
module tb_mux2_1_wide_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [63:0] in_d [0:1];
   logic [1:0]  last = 2'b11;
   logic [1:0]  gnt;
   logic [63:0] out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        owner;
   int          n_chk = 0;
   int          n_fail = 0;

   mux2_1_wide_arbiter #(.WIDTH(64)) dut (
      .clk(clk), .reset(reset), .req(req), .in(in_d), .last(last),
      .gnt(gnt), .out(out), .out_valid(out_valid), .out_ready(out_ready), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_d[0] = 64'h0;
      in_d[1] = 64'h0;
      #3;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_out", out, 64'd0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("idle_gnt", 64'(gnt), 64'd0);
         chk("idle_valid", 64'(out_valid), 64'd0);
         chk("idle_out", out, 64'd0);
         chk("idle_owner", 64'(owner), 64'd0);
      end
      in_d[0] = 64'hA;
      in_d[1] = 64'hB;
      req = 2'b11;
      last = 2'b11;
      for (int k = 0; k < 4; k++) begin
         chk("alt_idle_gnt", 64'(gnt), 64'd0);
         step();
         chk("alt_gnt", 64'(gnt), (k % 2) ? 64'd2 : 64'd1);
         chk("alt_owner", 64'(owner), 64'(k % 2));
         step();
         chk("alt_out", out, (k % 2) ? 64'hB : 64'hA);
         chk("alt_valid", 64'(out_valid), 64'd1);
      end
`ifndef ARB_BURST_LOCK_EN
      req = 2'b01;
      last = 2'b00;
      for (int k = 0; k < 3; k++) begin
         in_d[0] = 64'hC0 + 64'(k);
         chk("strm_idle_gnt", 64'(gnt), 64'd0);
         step();
         chk("strm_gnt", 64'(gnt), 64'd1);
         step();
         chk("strm_out", out, 64'hC0 + 64'(k));
         chk("strm_valid", 64'(out_valid), 64'd1);
      end
`endif
      req = 2'b01;
      last = 2'b11;
      in_d[0] = 64'hD0;
      step();
      chk("bp_gnt0", 64'(gnt), 64'd1);
      step();
      chk("bp_out0", out, 64'hD0);
      out_ready = 1'b0;
      in_d[0] = 64'hD1;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("bp_hold_gnt", 64'(gnt), 64'd0);
         chk("bp_hold_valid", 64'(out_valid), 64'd1);
         chk("bp_hold_out", out, 64'hD0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_gnt", 64'(gnt), 64'd1);
      step();
      chk("bp_load_out", out, 64'hD1);
      chk("bp_load_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      req = 2'b10;
      last = 2'b00;
      in_d[1] = 64'hE9;
      step();
      chk("mid_owner", 64'(owner), 64'd1);
      chk("mid_hold_gnt", 64'(gnt), 64'd0);
      out_ready = 1'b1;
      #1;
      chk("mid_gnt", 64'(gnt), 64'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_gnt", 64'(gnt), 64'd0);
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_out", out, 64'd0);
      chk("arst_owner", 64'(owner), 64'd0);
      reset = 1'b0;
      req = 2'b11;
      last = 2'b11;
      step();
      chk("post_rst_gnt", 64'(gnt), 64'd1);
      chk("post_rst_owner", 64'(owner), 64'd0);
`ifdef ARB_BURST_LOCK_EN
      step();
      last = 2'b01;
      for (int b = 0; b < 3; b++) begin
         in_d[1] = 64'hF0 + 64'(b);
         last[1] = (b == 2);
         if (b == 0) step();
         chk("burst_gnt", 64'(gnt), 64'd2);
         step();
         chk("burst_out", out, 64'hF0 + 64'(b));
      end
      step();
      chk("burst_next_gnt", 64'(gnt), 64'd1);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
